branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Next-generation branch resolution block. Evaluates RISC-V branch conditions in execute, as before, and adds a parametrised bimodal branch history table (BHT) of 2-bit saturating counters. The BHT gives fetch a taken/not-taken prediction. The block registers the resolution result with one-cycle latency and flags mispredictions with the redirect PC. It sits between the fetch PC mux and the execute stage.

Parameters:
DATA_WIDTH, 32, operand width for comparisons.
PC_WIDTH, 32, program-counter width.
BHT_DEPTH, 64, number of BHT entries; power of 2, minimum 2.
CTR_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_fetch_pc  input  PC_WIDTH  PC being fetched, used for the prediction lookup.
o_pred_take  output  1  combinational prediction: MSB of BHT[index(i_fetch_pc)].
i_valid  input  1  execute-stage instruction is valid.
i_branch  input  1  instruction is a branch or jump.
i_branch_op  input  3  condition, encoded with the shared `BRANCH_* definitions (BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL_JALR).
i_a  input  DATA_WIDTH  rs1 value.
i_b  input  DATA_WIDTH  rs2 value.
i_pc  input  PC_WIDTH  PC of the execute instruction.
i_pred_take  input  1  prediction made at fetch, carried down the pipe.
i_target  input  PC_WIDTH  computed branch or jump target.
i_stall  input  1  hold the execute stage.
i_flush  input  1  kill the execute-stage instruction.
o_valid  output  1  registered: a resolution result is present.
o_take  output  1  registered: the branch/jump is taken.
o_mispredict  output  1  registered: the actual outcome differs from i_pred_take.
o_redirect_pc  output  PC_WIDTH  registered: correct next PC.

Behaviour:
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1 : 2].
- Condition evaluation (combinational, internal):
  - BEQ / BNE: equality and inequality.
  - BLT / BGE: signed compare.
  - BLTU / BGEU: unsigned compare.
  - JAL_JALR: always taken.
  - Unknown op, or i_branch=0: not taken.
- Resolve: res = i_valid & i_branch & ~i_flush.
- Output register update, when ~i_stall:
  - o_valid <= res.
  - o_take <= res & cond.
  - o_mispredict <= res & (cond != i_pred_take).
  - o_redirect_pc <= cond ? i_target : i_pc + 4 (modulo 2^PC_WIDTH).
  - When res=0, all four outputs are cleared to 0.
- Latency: exactly 1 cycle from execute inputs to outputs.
- Stall: i_stall=1 holds all output registers and suppresses any BHT update. Stall has priority over new inputs; flush has priority over stall.
- Flush: i_flush=1 clears o_valid, o_take and o_mispredict next cycle even if i_stall=1. No BHT update.
- BHT update, same edge as the output register, only for res & ~i_stall & op != JAL_JALR:
  - taken: counter increments, saturating at 3.
  - not taken: counter decrements, saturating at 0.
  - JAL/JALR never touches the BHT.
- Read/update collision: when i_fetch_pc and i_pc share an index in the same cycle, o_pred_take returns the pre-update value. There is no bypass.
- Reset: on i_rst, all BHT entries <= CTR_INIT. o_valid, o_take, o_mispredict <= 0. o_redirect_pc <= 0. Reset overrides stall and flush; reset applied mid-stream discards the in-flight instruction.
- Aliasing: PCs sharing an index share a counter. No tags.

Optional Feature:
BRANCH_STATS_EN. When defined, adds two outputs:
- o_br_count [31:0]: increments on every cycle that updates the output registers with res=1.
- o_mp_count [31:0]: increments when o_mispredict is set.
- Both saturate at 32'hFFFF_FFFF and clear on i_rst.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then BHT_DEPTH=64 with i_fetch_pc=0x100: o_pred_take=0 for every index; all registered outputs 0.
- BEQ, i_a=i_b=5, i_pc=0x100, i_target=0x140, i_pred_take=0: next cycle o_take=1, o_mispredict=1, o_redirect_pc=0x140. Then i_fetch_pc=0x100 gives o_pred_take=1 (counter 2).
- BLT with i_a=0xFFFFFFFF, i_b=1 -> taken. BLTU with the same operands -> not taken, o_redirect_pc=i_pc+4.
- Four consecutive taken BNE at the same PC: counter saturates at 3. Then a single not-taken gives counter 2, and o_pred_take stays 1.
- JAL, i_pred_take=1: o_take=1, o_mispredict=0, BHT entry unchanged. i_flush=1 with a valid BEQ: o_valid=0, no counter change.
- i_stall=1 for 3 cycles with a changing BGE input: outputs frozen and counters unchanged. i_rst asserted during the stall clears everything next edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Execute-stage branch resolution with a bimodal branch history table
//   (BHT) of 2-bit saturating counters that supplies fetch-time predictions.
//   Resolution results are registered (one-cycle latency) together with
//   the mispredict flag and the corrected next PC.
//
//   Optional build macro: BRANCH_STATS_EN adds the saturating branch and
//   mispredict counters o_br_count / o_mp_count.

`ifndef BRANCH_BEQ
`define BRANCH_BEQ      3'd0
`endif
`ifndef BRANCH_BNE
`define BRANCH_BNE      3'd1
`endif
`ifndef BRANCH_BLT
`define BRANCH_BLT      3'd2
`endif
`ifndef BRANCH_BGE
`define BRANCH_BGE      3'd3
`endif
`ifndef BRANCH_BLTU
`define BRANCH_BLTU     3'd4
`endif
`ifndef BRANCH_BGEU
`define BRANCH_BGEU     3'd5
`endif
`ifndef BRANCH_JAL_JALR
`define BRANCH_JAL_JALR 3'd6
`endif

module branch_predict_unit #(
  parameter int         DATA_WIDTH = 32,
  parameter int         PC_WIDTH   = 32,
  parameter int         BHT_DEPTH  = 64,
  parameter logic [1:0] CTR_INIT   = 2'b01
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PC_WIDTH-1:0]   i_fetch_pc,
  output logic                  o_pred_take,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic [2:0]            i_branch_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_pred_take,
  input  logic [PC_WIDTH-1:0]   i_target,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_take,
  output logic                  o_mispredict,
  output logic [PC_WIDTH-1:0]   o_redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           o_br_count,
  output logic [31:0]           o_mp_count
`endif
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  // Saturating 32-bit event counter increment.
  function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [1:0]                   bht_q [BHT_DEPTH];
  logic [IDX_W-1:0]             fetch_idx;
  logic [IDX_W-1:0]             upd_idx_p0;
  logic signed [DATA_WIDTH-1:0] a_s_p0;
  logic signed [DATA_WIDTH-1:0] b_s_p0;
  logic                         cond_p0;
  logic                         res_p0;
  logic                         mp_p0;
  logic                         bht_we_p0;
  logic                         out_upd_p0;
  logic [PC_WIDTH-1:0]          pc_plus4_p0;
  logic [PC_WIDTH-1:0]          redir_p0;
  logic                         vld_p1;
  logic                         take_p1;
  logic                         mp_p1;
  logic [PC_WIDTH-1:0]          redir_p1;
  logic                         unused_fetch_bits;

  // ---- stage p0: fetch lookup and execute-stage condition evaluation ----
  assign fetch_idx         = i_fetch_pc[IDX_W+1:2];
  assign upd_idx_p0        = i_pc[IDX_W+1:2];
  assign o_pred_take       = bht_q[fetch_idx][1];
  assign unused_fetch_bits = ^i_fetch_pc;

  assign a_s_p0 = i_a;
  assign b_s_p0 = i_b;

  // Branch condition; anything that is not a recognised branch resolves not-taken.
  always_comb begin
    cond_p0 = 1'b0;
    if (i_branch) begin
      case (i_branch_op)
        `BRANCH_BEQ:      cond_p0 = (i_a == i_b);
        `BRANCH_BNE:      cond_p0 = (i_a != i_b);
        `BRANCH_BLT:      cond_p0 = (a_s_p0 <  b_s_p0);
        `BRANCH_BGE:      cond_p0 = (a_s_p0 >= b_s_p0);
        `BRANCH_BLTU:     cond_p0 = (i_a <  i_b);
        `BRANCH_BGEU:     cond_p0 = (i_a >= i_b);
        `BRANCH_JAL_JALR: cond_p0 = 1'b1;
        default:          cond_p0 = 1'b0;
      endcase
    end
  end

  assign res_p0      = i_valid & i_branch & ~i_flush;
  assign mp_p0       = res_p0 & (cond_p0 != i_pred_take);
  assign pc_plus4_p0 = i_pc + PC_WIDTH'(4);
  assign redir_p0    = res_p0 ? (cond_p0 ? i_target : pc_plus4_p0) : '0;
  // A flush must land even while stalled, so it opens the output register too.
  assign out_upd_p0  = ~i_stall | i_flush;
  assign bht_we_p0   = res_p0 & ~i_stall & (i_branch_op != `BRANCH_JAL_JALR);

  // ---- stage p1: registered resolution result ----
  // Output register: reset clears, stall holds, flush or normal flow reloads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1   <= 1'b0;
      take_p1  <= 1'b0;
      mp_p1    <= 1'b0;
      redir_p1 <= '0;
    end else if (out_upd_p0) begin
      vld_p1   <= res_p0;
      take_p1  <= res_p0 & cond_p0;
      mp_p1    <= mp_p0;
      redir_p1 <= redir_p0;
    end
  end

  // BHT training on resolved conditional branches; reads see pre-update values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_INIT;
    end else if (bht_we_p0) begin
      bht_q[upd_idx_p0] <= ctr_next(bht_q[upd_idx_p0], cond_p0);
    end
  end

  assign o_valid       = vld_p1;
  assign o_take        = take_p1;
  assign o_mispredict  = mp_p1;
  assign o_redirect_pc = redir_p1;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_p1;
  logic [31:0] mp_cnt_p1;

  // Event counters track results actually written into the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_cnt_p1 <= '0;
      mp_cnt_p1 <= '0;
    end else if (out_upd_p0 && res_p0) begin
      br_cnt_p1 <= sat_inc32(br_cnt_p1);
      if (mp_p0) mp_cnt_p1 <= sat_inc32(mp_cnt_p1);
    end
  end

  assign o_br_count = br_cnt_p1;
  assign o_mp_count = mp_cnt_p1;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed sequences, a vector table and
// randomized traffic checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_branch_predict_unit;

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLT  = 3'd2;
  localparam logic [2:0] OP_BGE  = 3'd3;
  localparam logic [2:0] OP_BLTU = 3'd4;
  localparam logic [2:0] OP_BGEU = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_BAD  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_take;
  logic        valid, branch;
  logic [2:0]  op;
  logic [31:0] a, b, pc, tgt;
  logic        pred, stall, flush;
  logic        o_valid, o_take, o_mispredict;
  logic [31:0] o_redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, mp_count;
  longint      m_br, m_mp;
`endif

  int checks = 0;
  int errors = 0;
  bit pre_ok = 0;

  // Reference state: plain integer counters per table slot and expected outputs.
  int          m_ctr [64];
  bit          m_valid, m_take, m_mp;
  logic [31:0] m_redir;

  branch_predict_unit dut (
    .i_clk(clk), .i_rst(rst), .i_fetch_pc(fetch_pc), .o_pred_take(pred_take),
    .i_valid(valid), .i_branch(branch), .i_branch_op(op), .i_a(a), .i_b(b),
    .i_pc(pc), .i_pred_take(pred), .i_target(tgt), .i_stall(stall), .i_flush(flush),
    .o_valid(o_valid), .o_take(o_take), .o_mispredict(o_mispredict),
    .o_redirect_pc(o_redirect_pc)
`ifdef BRANCH_STATS_EN
    , .o_br_count(br_count), .o_mp_count(mp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] p);
    return int'((p / 4) % 64);
  endfunction

  function automatic longint as_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic bit model_cond(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      OP_BEQ:  return x == y;
      OP_BNE:  return x != y;
      OP_BLT:  return as_signed(x) < as_signed(y);
      OP_BGE:  return as_signed(x) >= as_signed(y);
      OP_BLTU: return longint'(x) < longint'(y);
      OP_BGEU: return longint'(x) >= longint'(y);
      OP_JAL:  return 1;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock using the currently applied inputs.
  task automatic model_update();
    bit res, c;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_valid = 0; m_take = 0; m_mp = 0; m_redir = 0;
`ifdef BRANCH_STATS_EN
      m_br = 0; m_mp = 0;
`endif
    end else if (flush || !stall) begin
      res = valid && branch && !flush;
      c   = branch && model_cond(op, a, b);
      m_valid = res;
      m_take  = res && c;
      m_mp    = res && (c != pred);
      m_redir = !res ? 32'd0 : (c ? tgt : pc + 32'd4);
`ifdef BRANCH_STATS_EN
      if (res) begin
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (m_mp && m_mp < 64'hFFFF_FFFF) m_mp++;
      end
`endif
      if (res && op != OP_JAL) begin
        if (c) m_ctr[midx(pc)] = (m_ctr[midx(pc)] < 3) ? m_ctr[midx(pc)] + 1 : 3;
        else   m_ctr[midx(pc)] = (m_ctr[midx(pc)] > 0) ? m_ctr[midx(pc)] - 1 : 0;
      end
    end
  endtask

  // One clock: pre-edge prediction check, edge, then all outputs vs model.
  task automatic cycle();
    #1;
    if (pre_ok) chk("pred_pre_edge", pred_take, m_ctr[midx(fetch_pc)] >= 2);
    model_update();
    @(posedge clk);
    #1;
    chk("o_valid", o_valid, m_valid);
    chk("o_take", o_take, m_take);
    chk("o_mispredict", o_mispredict, m_mp);
    chk("o_redirect_pc", o_redirect_pc, m_redir);
    chk("pred_post_edge", pred_take, m_ctr[midx(fetch_pc)] >= 2);
`ifdef BRANCH_STATS_EN
    chk("o_br_count", br_count, m_br);
    chk("o_mp_count", mp_count, m_mp);
`endif
    pre_ok = 1;
  endtask

  task automatic set_br(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] p, input logic [31:0] t, input logic pr);
    valid = 1; branch = 1; op = o; a = x; b = y; pc = p; tgt = t; pred = pr;
    stall = 0; flush = 0; rst = 0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pc, tgt;
    logic        pred;
    logic        e_take, e_mp;
    logic [31:0] e_redir;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{OP_BEQ,  32'd5,        32'd5,        32'h100,      32'h140, 1'b0, 1'b1, 1'b1, 32'h140};
    vecs[1] = '{OP_BNE,  32'd5,        32'd5,        32'h200,      32'h300, 1'b0, 1'b0, 1'b0, 32'h204};
    vecs[2] = '{OP_BLT,  32'hFFFFFFFF, 32'd1,        32'h300,      32'h380, 1'b0, 1'b1, 1'b1, 32'h380};
    vecs[3] = '{OP_BLTU, 32'hFFFFFFFF, 32'd1,        32'h300,      32'h380, 1'b1, 1'b0, 1'b1, 32'h304};
    vecs[4] = '{OP_BGE,  32'd1,        32'hFFFFFFFF, 32'h400,      32'h480, 1'b1, 1'b1, 1'b0, 32'h480};
    vecs[5] = '{OP_BGEU, 32'd1,        32'hFFFFFFFF, 32'h404,      32'h480, 1'b0, 1'b0, 1'b0, 32'h408};
    vecs[6] = '{OP_JAL,  32'd0,        32'd0,        32'h500,      32'h900, 1'b1, 1'b1, 1'b0, 32'h900};
    vecs[7] = '{OP_BAD,  32'd3,        32'd3,        32'h504,      32'h900, 1'b1, 1'b0, 1'b1, 32'h508};
    vecs[8] = '{OP_BEQ,  32'd1,        32'd2,        32'hFFFFFFFC, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0};

    rst = 1; fetch_pc = 32'h100; valid = 0; branch = 0; op = OP_BEQ;
    a = 0; b = 0; pc = 0; tgt = 0; pred = 0; stall = 0; flush = 0;
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_valid = 0; m_take = 0; m_mp = 0; m_redir = 0;
`ifdef BRANCH_STATS_EN
    m_br = 0; m_mp = 0;
`endif

    // Reset state: every index predicts not-taken, registered outputs zero.
    cycle();
    rst = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_redirect", o_redirect_pc, 0);
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'h100 + 32'(i * 4);
      #1;
      chk("rst_pred_idx", pred_take, 0);
    end

    // Taken BEQ trains idx 0 from 1 to 2.
    fetch_pc = 32'h100;
    set_br(OP_BEQ, 5, 5, 32'h100, 32'h140, 0);
    cycle();
    chk("beq_take", o_take, 1);
    chk("beq_mp", o_mispredict, 1);
    chk("beq_redir", o_redirect_pc, 32'h140);
    chk("beq_pred", pred_take, 1);

    // Four taken BNE saturate, one not-taken keeps prediction, second drops it.
    fetch_pc = 32'h180;
    for (int i = 0; i < 4; i++) begin
      set_br(OP_BNE, 1, 2, 32'h180, 32'h1C0, 1);
      cycle();
    end
    chk("bne_sat_pred", pred_take, 1);
    set_br(OP_BNE, 4, 4, 32'h180, 32'h1C0, 1);
    cycle();
    chk("bne_nt_pred", pred_take, 1);
    chk("bne_nt_mp", o_mispredict, 1);
    chk("bne_nt_redir", o_redirect_pc, 32'h184);
    cycle();
    chk("bne_nt2_pred", pred_take, 0);

    // JAL leaves idx 0 at 2; a following not-taken drops it to 1.
    fetch_pc = 32'h100;
    set_br(OP_JAL, 0, 0, 32'h100, 32'h800, 1);
    cycle();
    chk("jal_take", o_take, 1);
    chk("jal_mp", o_mispredict, 0);
    chk("jal_redir", o_redirect_pc, 32'h800);
    set_br(OP_BEQ, 1, 2, 32'h100, 32'h140, 1);
    cycle();
    chk("jal_no_train", pred_take, 0);

    // Flushed BEQ: no result, no training. Then same BEQ unflushed (collision).
    fetch_pc = 32'h204;
    set_br(OP_BEQ, 3, 3, 32'h204, 32'h300, 0);
    flush = 1;
    cycle();
    chk("flush_valid", o_valid, 0);
    chk("flush_pred", pred_take, 0);
    flush = 0;
    #1;
    chk("collide_pre", pred_take, 0);
    cycle();
    chk("collide_post", pred_take, 1);

    // Stall freezes outputs and BHT; reset during stall clears everything.
    set_br(OP_BGE, 3, 2, 32'h20C, 32'h400, 0);
    cycle();
    fetch_pc = 32'h208;
    for (int i = 0; i < 3; i++) begin
      set_br(OP_BGE, 32'(5 + i * 2), 32'(1 + i), 32'h208, 32'h500 + 32'(i * 4), 0);
      stall = 1;
      cycle();
      chk("stall_valid", o_valid, 1);
      chk("stall_take", o_take, 1);
      chk("stall_redir", o_redirect_pc, 32'h400);
    end
    chk("stall_no_train", pred_take, 0);
    rst = 1;
    cycle();
    chk("rst_stall_valid", o_valid, 0);
    chk("rst_stall_mp", o_mispredict, 0);
    chk("rst_stall_redir", o_redirect_pc, 0);
    rst = 0; stall = 0;
    fetch_pc = 32'h204;
    #1;
    chk("rst_stall_bht", pred_take, 0);

    // Vector table.
    foreach (vecs[i]) begin
      set_br(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].tgt, vecs[i].pred);
      cycle();
      chk("vec_valid", o_valid, 1);
      chk("vec_take", o_take, vecs[i].e_take);
      chk("vec_mp", o_mispredict, vecs[i].e_mp);
      chk("vec_redir", o_redirect_pc, vecs[i].e_redir);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] vals [6];
      vals[0] = 0; vals[1] = 1; vals[2] = 32'hFFFFFFFF; vals[3] = 32'h80000000;
      vals[4] = 32'h7FFFFFFF; vals[5] = $urandom;
      rst    = ($urandom_range(0, 199) == 0);
      valid  = ($urandom_range(0, 9) < 8);
      branch = ($urandom_range(0, 9) < 9);
      op     = 3'($urandom_range(0, 7));
      a      = vals[$urandom_range(0, 5)];
      b      = ($urandom_range(0, 3) == 0) ? a : vals[$urandom_range(0, 5)];
      pc     = 32'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFFFFFC;
      tgt    = $urandom & 32'hFFFFFFFC;
      pred   = 1'($urandom_range(0, 1));
      stall  = ($urandom_range(0, 4) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      fetch_pc = ($urandom_range(0, 2) == 0) ? pc : 32'($urandom_range(0, 255)) * 4;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
